// File: rtl/mh_lp_bridge_buffer.sv
// Ping-pong tile buffer between linear projection and multi-head attention.
// Each bank holds NUM_HEADS DIMxDIM tiles; each bank is replayed row-wise or transposed.
module mh_lp_bridge_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 4,
  parameter int NUM_HEADS  = 2,
  parameter int HEAD_W     = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
  parameter int IDX_W      = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*DATA_WIDTH-1:0] in_data,
  input  logic                      in_last,
  input  logic                      in_transpose,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIM*DATA_WIDTH-1:0] out_data,
  output logic [HEAD_W-1:0]         out_head,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      err_last,
  output logic [1:0]                bank_full
);

  // state    | meaning
  // EMPTY    | bank free, waiting for its first write beat
  // FILLING  | bank partially written
  // FULL     | bank complete, nothing read yet
  // DRAINING | bank being replayed to attention
  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_DRAINING} bank_st_e;

  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic [1:0]        mode_q, mode_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [HEAD_W-1:0] wr_head_q, wr_head_d, rd_head_q, rd_head_d;
  logic [IDX_W-1:0]  wr_row_q, wr_row_d, rd_idx_q, rd_idx_d;
  logic              err_last_q, err_last_d;
  logic [DATA_WIDTH-1:0] mem_q [2][NUM_HEADS][DIM][DIM];
  logic [DATA_WIDTH-1:0] mem_d [2][NUM_HEADS][DIM][DIM];

  logic wr_fire, wr_final, rd_fire;

  assign in_ready  = !rst && (st_q[wr_bank_q] == S_EMPTY || st_q[wr_bank_q] == S_FILLING);
  assign out_valid = (st_q[rd_bank_q] == S_FULL || st_q[rd_bank_q] == S_DRAINING);
  assign wr_fire   = in_valid && in_ready;
  assign wr_final  = (wr_head_q == HEAD_W'(NUM_HEADS-1)) && (wr_row_q == IDX_W'(DIM-1));
  assign out_last  = (rd_head_q == HEAD_W'(NUM_HEADS-1)) && (rd_idx_q == IDX_W'(DIM-1));
  assign rd_fire   = out_valid && out_ready;
  assign out_head  = rd_head_q;
  assign out_idx   = rd_idx_q;
  assign err_last  = err_last_q;

  always_comb begin
    for (int b = 0; b < 2; b++)
      bank_full[b] = (st_q[b] == S_FULL || st_q[b] == S_DRAINING);
  end

  // Transpose mode reads column rd_idx instead of row rd_idx.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < DIM; j++)
      out_data[j*DATA_WIDTH +: DATA_WIDTH] = mode_q[rd_bank_q] ?
          mem_q[rd_bank_q][rd_head_q][j][rd_idx_q] :
          mem_q[rd_bank_q][rd_head_q][rd_idx_q][j];
  end

  always_comb begin
    st_d       = st_q;
    mode_d     = mode_q;
    wr_bank_d  = wr_bank_q;
    wr_head_d  = wr_head_q;
    wr_row_d   = wr_row_q;
    rd_bank_d  = rd_bank_q;
    rd_head_d  = rd_head_q;
    rd_idx_d   = rd_idx_q;
    err_last_d = err_last_q;
    mem_d      = mem_q;

    if (wr_fire) begin
      for (int j = 0; j < DIM; j++)
        mem_d[wr_bank_q][wr_head_q][wr_row_q][j] = in_data[j*DATA_WIDTH +: DATA_WIDTH];
      if (st_q[wr_bank_q] == S_EMPTY) begin
        st_d[wr_bank_q]   = S_FILLING;
        mode_d[wr_bank_q] = in_transpose;
      end
      // Beat counter is authoritative; a disagreeing in_last is only flagged.
      if (in_last != wr_final)
        err_last_d = 1'b1;
      if (wr_final) begin
        st_d[wr_bank_q] = S_FULL;
        wr_head_d       = '0;
        wr_row_d        = '0;
        wr_bank_d       = ~wr_bank_q;
      end else if (wr_row_q == IDX_W'(DIM-1)) begin
        wr_row_d  = '0;
        wr_head_d = wr_head_q + 1'b1;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (out_last) begin
        st_d[rd_bank_q] = S_EMPTY;
        rd_head_d       = '0;
        rd_idx_d        = '0;
        rd_bank_d       = ~rd_bank_q;
      end else begin
        st_d[rd_bank_q] = S_DRAINING;
        if (rd_idx_q == IDX_W'(DIM-1)) begin
          rd_idx_d  = '0;
          rd_head_d = rd_head_q + 1'b1;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]    <= S_EMPTY;
      st_q[1]    <= S_EMPTY;
      mode_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_head_q  <= '0;
      wr_row_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_head_q  <= '0;
      rd_idx_q   <= '0;
      err_last_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      mode_q     <= mode_d;
      wr_bank_q  <= wr_bank_d;
      wr_head_q  <= wr_head_d;
      wr_row_q   <= wr_row_d;
      rd_bank_q  <= rd_bank_d;
      rd_head_q  <= rd_head_d;
      rd_idx_q   <= rd_idx_d;
      err_last_q <= err_last_d;
    end
  end

  // Tile storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mh_lp_bridge_buffer.sv
// Scoreboard bench for mh_lp_bridge_buffer: tiles carry 0xSHRC-coded elements,
// expected read beats are queued when a bank completes and checked on every valid cycle.
module tb_mh_lp_bridge_buffer;
  localparam int DW = 16;
  localparam int DIM = 4;
  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          in_transpose = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_data;
  logic [0:0]    out_head;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          err_last;
  logic [1:0]    bank_full;

  typedef struct packed {
    logic [63:0] data;
    logic [0:0]  head;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    rd_cnt = 0;
  bit    stop_rand = 0;

  mh_lp_bridge_buffer #(.DATA_WIDTH(DW), .DIM(DIM), .NUM_HEADS(NH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_transpose(in_transpose),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_head(out_head), .out_idx(out_idx), .out_last(out_last),
    .err_last(err_last), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ev(input logic [3:0] seed, input int h, input int r, input int c);
    return {seed, 4'(h), 4'(r), 4'(c)};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        check("out_data", out_data, exp_q[0].data);
        check("out_head", out_head, exp_q[0].head);
        check("out_idx",  out_idx,  exp_q[0].idx);
        check("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          void'(exp_q.pop_front());
          rd_cnt++;
        end
      end
    end
  end

  // Call between a posedge and the next negedge; returns #1 after the final accepting posedge.
  task automatic write_bank(input logic [3:0] seed, input logic tr, input int bad,
                            input bit low_final, input bit chk_err);
    int waited;
    beat_t e;
    for (int b = 0; b < NH*DIM; b++) begin
      for (int c = 0; c < DIM; c++)
        in_data[c*DW +: DW] = ev(seed, b / DIM, b % DIM, c);
      in_valid     = 1'b1;
      in_last      = ((b == NH*DIM-1) && !low_final) || (b == bad);
      in_transpose = (b == 0) ? tr : ~tr;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check("wr_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (chk_err) check("err_last_seq", err_last, (b >= bad));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int h = 0; h < NH; h++)
      for (int k = 0; k < DIM; k++) begin
        for (int j = 0; j < DIM; j++)
          e.data[j*DW +: DW] = tr ? ev(seed, h, j, k) : ev(seed, h, k, j);
        e.head = 1'(h);
        e.idx  = 2'(k);
        e.last = (h == NH-1) && (k == DIM-1);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, n;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_bank_full", bank_full, 2'b00);
    check("rst_err_last", err_last, 1'b0);
    sync();
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1'b1);

    // Normal-mode bank, reader always ready.
    out_ready = 1'b1;
    write_bank(4'h0, 1'b0, -1, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_valid", out_valid, 1'b1);
    check("beat0_normal", out_data, 64'h0003_0002_0001_0000);
    wait_drain();

    // Transposed bank; in_transpose toggles after beat 0 must be ignored.
    sync();
    write_bank(4'h0, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    check("beat0_transpose", out_data, 64'h0030_0020_0010_0000);
    wait_drain();

    // Both banks full, then release the reader.
    sync();
    out_ready = 1'b0;
    write_bank(4'h2, 1'b0, -1, 1'b0, 1'b0);
    write_bank(4'h3, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    check("full_bank_full", bank_full, 2'b11);
    sync();
    out_ready = 1'b1;
    for (int k = 0; k < NH*DIM; k++) begin
      @(negedge clk);
      check("blocked_in_ready", in_ready, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    check("reopen_in_ready", in_ready, 1'b1);
    wait_drain();

    // Random reader stalls during concurrent fills of four banks.
    sync();
    stop_rand = 0;
    fork
      begin
        for (int s = 0; s < 4; s++)
          write_bank(4'(4 + s), 1'(s % 2), -1, 1'b0, 1'b0);
        stop_rand = 1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // in_last early on beat 3 and missing on the final beat.
    sync();
    check("pre_err_last", err_last, 1'b0);
    write_bank(4'h8, 1'b0, 3, 1'b1, 1'b1);
    wait_drain();
    check("post_err_last", err_last, 1'b1);

    // Reset in the middle of a drain.
    sync();
    out_ready = 1'b0;
    write_bank(4'h9, 1'b1, -1, 1'b0, 1'b0);
    out_ready = 1'b1;
    base = rd_cnt;
    n = 0;
    while (rd_cnt < base + 6 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("rst_drain_reads", rd_cnt - base, 6);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_bank_full", bank_full, 2'b00);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_err_last", err_last, 1'b0);
    sync();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    write_bank(4'hA, 1'b0, -1, 1'b0, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mh_lp_bridge_buffer.md
Name: mh_lp_bridge_buffer

Overview:
- Ping-pong tile buffer between the linear-projection stage and multi-head self-attention.
- Collects one DIMxDIM tile per head, written row by row, head-major, into one of two banks.
- Replays each tile to attention either row-wise or column-wise (transposed, for K^T) under a per-bank mode.
- Generalises the single-head, row-only bridge to NUM_HEADS channels, with a runtime transpose mode and valid/ready on both sides.

Parameters:
- DATA_WIDTH, 16, width of one fixed-point element.
- DIM, 4, tile edge; rows = cols = DIM (>=2).
- NUM_HEADS, 2, number of heads per bank (>=1).
- HEAD_W, $clog2(NUM_HEADS) min 1, derived, head index width.
- IDX_W, $clog2(DIM) min 1, derived, row/column index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  write beat valid.
- in_ready  out  1  write beat accepted when in_valid && in_ready at posedge.
- in_data  in  DIM*DATA_WIDTH  one tile row; element j at [j*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  1  marks the final beat of a bank (beat NUM_HEADS*DIM-1).
- in_transpose  in  1  read mode for the bank, sampled on the bank's first write beat.
- out_valid  out  1  read beat valid.
- out_ready  in  1  read beat consumed when out_valid && out_ready at posedge.
- out_data  out  DIM*DATA_WIDTH  row r (normal) or column c (transpose) of the current head tile; same packing as in_data.
- out_head  out  HEAD_W  head of the current beat.
- out_idx  out  IDX_W  row or column index of the current beat.
- out_last  out  1  final beat of the bank.
- err_last  out  1  sticky in_last protocol error.
- bank_full  out  2  per-bank FULL/DRAINING status.

Behaviour:
- Storage: 2 banks x NUM_HEADS x DIM x DIM registers; per-bank state EMPTY, FILLING, FULL, DRAINING plus a latched mode bit.
- Write pointer wr_bank with counters (head, row). Order: head 0 rows 0..DIM-1, then head 1, and so on.
- in_ready = !rst && wr_bank state in {EMPTY, FILLING}.
- On an accepted beat, in_data is stored to [wr_bank][head][row].
  - First beat of a bank: EMPTY->FILLING and mode latched from in_transpose.
  - Beat NUM_HEADS*DIM-1: bank ->FULL, counters cleared, wr_bank toggles.
- The counter alone decides bank completion. If in_last disagrees with the counter (high early or low on the final beat), err_last sets and stays set until rst; the beat is still accepted.
- Read pointer rd_bank with counters (head, idx). out_valid = rd_bank state in {FULL, DRAINING}.
- out_data, out_head, out_idx, out_last are combinational from storage and counters.
  - Normal mode: out_data element j = tile[head][idx][j].
  - Transpose mode: out_data element j = tile[head][j][idx].
- On the first accepted read the bank goes FULL->DRAINING.
- On the accepted read with head=NUM_HEADS-1 and idx=DIM-1 (out_last=1): bank ->EMPTY, counters cleared, rd_bank toggles.
- Latency: out_valid rises the cycle after the posedge that accepted a bank's final write beat; zero bubbles between beats while out_ready stays high.
- Sustained throughput is 1 beat/cycle on each side; fill and drain of opposite banks are fully concurrent.
- Stall: while out_valid && !out_ready, every out_* signal holds stable.
- Both banks full: in_ready=0 until the drain of the bank at wr_bank completes. in_ready rises the cycle after that final out handshake; no combinational ready->ready path.
- Write and read on the same cycle to different banks are independent. The same bank cannot be written and read at once by construction.
- Reset (any time, including mid-fill or mid-drain): banks EMPTY, pointers and counters 0, mode bits 0. Outputs: out_valid=0, in_ready=0 while rst high, err_last=0, bank_full=0. Storage contents are don't-care. in_ready=1 from the first posedge-free cycle after rst deasserts.
- bank_full[b] = bank b in {FULL, DRAINING}.

Test Plan:
- DIM=4, NUM_HEADS=2, DATA_WIDTH=16, element value = {head,row,col} encoded 0xHRC. Write 8 beats, in_transpose=0, out_ready=1 -> out_valid one cycle after the last write. 8 beats: head0 rows 0..3 then head1; beat0 = {0x003,0x002,0x001,0x000}; out_last only on beat 7.
- Same tile with in_transpose=1 -> beat k of head h carries column k: head1 beat2 = {0x132,0x122,0x112,0x102}. Mode ignores later toggles of in_transpose within the bank.
- Write 16 beats back-to-back, out_ready=0 -> in_ready drops after beat 16, bank_full=2'b11. Raise out_ready -> in_ready returns the cycle after the 8th read; bank0 data precedes bank1.
- Random out_ready with 50% stalls during a concurrent fill -> out_data stable in every stalled cycle. Scoreboard matches 32 beats across 4 banks with alternating modes.
- in_last on beat 3 and low on beat 7 -> err_last=1 from beat 3 onward; bank still completes after 8 beats, and data is correct.
- Assert rst mid-drain (after read beat 5) -> out_valid=0 and bank_full=0 immediately. in_ready=1 after release; a new bank fills and reads correctly from head0 row0.
